// File: rtl/e_calc_pkg.sv
// Shared types and defaults for the e calculator datapath: operand words,
// squaring-scheduler state encoding and default sizing.
package e_calc_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIN,
        ABORT
    } sched_state_t;

    localparam int WORDS_DEF   = 32;
    localparam int LOG2_N_DEF  = 15;
    localparam int TIMEOUT_DEF = 4096;

    // Iteration counter width; stays at 1 bit when no passes are configured.
    function automatic int iter_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/e_square_sched.sv
// Computes X^(2^LOG2_N) by driving LOG2_N squaring passes through an external
// shared multiplier, with a per-pass watchdog that aborts a stalled pass.
module e_square_sched
    import e_calc_pkg::*;
#(
    parameter int WORDS   = WORDS_DEF,
    parameter int LOG2_N  = LOG2_N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [16*WORDS-1:0]       in_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [iter_w(LOG2_N)-1:0] iter,
    output logic [16*WORDS-1:0]       out_data,
    output logic                      mul_start,
    output logic [16*WORDS-1:0]       mul_a,
    output logic [16*WORDS-1:0]       mul_b,
    input  logic                      mul_done,
    input  logic [16*WORDS-1:0]       mul_product
);

    localparam int IW = iter_w(LOG2_N);
    localparam int WW = $clog2(TIMEOUT);

    sched_state_t             state, nstate;
    word_t [WORDS-1:0]        bank;
    logic  [IW-1:0]           iter_q;
    logic  [WW-1:0]           wd;
    logic                     last_pass;
    logic                     wd_expired;

    assign last_pass  = (int'(iter_q) + 1) >= LOG2_N;
    assign wd_expired = (wd == WW'(TIMEOUT - 1));

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (start) nstate = (LOG2_N == 0) ? FIN : ISSUE;
            ISSUE: nstate = WAIT;
            // A completion arriving on the expiry cycle still counts.
            WAIT: begin
                if (mul_done)        nstate = last_pass ? FIN : ISSUE;
                else if (wd_expired) nstate = ABORT;
            end
            FIN:   nstate = IDLE;
            ABORT: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bank   <= '0;
            iter_q <= '0;
            wd     <= '0;
        end else begin
            state <= nstate;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bank   <= in_data;
                        iter_q <= '0;
                        wd     <= '0;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    if (mul_done) begin
                        bank   <= mul_product;
                        iter_q <= iter_q + IW'(1);
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done      = (state == FIN);
    assign err       = (state == ABORT);
    assign mul_start = (state == ISSUE);
    assign iter      = iter_q;
    assign out_data  = bank;
    // Operands come straight from the bank, which only moves on a capture edge.
    assign mul_a     = bank;
    assign mul_b     = bank;

endmodule

// File: tb/tb_e_square_sched.sv
// Randomized bench for e_square_sched: a run-level reference model predicts
// every output per cycle from start time, latency and pass count.
module tb_e_square_sched;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance: LOG2_N=3, TIMEOUT=16
    logic        start = 1'b0, busy, done, err, mul_start, mul_done;
    logic [1:0]  iter;
    logic [63:0] in_data = '0, out_data, mul_a, mul_b, mul_product;

    // second instance: LOG2_N=2, fixed multiplier latency 3
    logic        t_start = 1'b0, t_busy, t_done, t_err, t_ms, t_md = 1'b0;
    logic [1:0]  t_iter;
    logic [63:0] t_in = '0, t_out, t_a, t_b, t_prod = '0;

    // third instance: LOG2_N=0, no multiplier attached
    logic        z_start = 1'b0, z_busy, z_done, z_err, z_ms;
    logic        z_md = 1'b0;
    logic [0:0]  z_iter;
    logic [63:0] z_in = '0, z_out, z_a, z_b;
    logic [63:0] z_prod = '0;

    e_square_sched #(.WORDS(W), .LOG2_N(N), .TIMEOUT(TO)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .busy(busy), .done(done), .err(err), .iter(iter), .out_data(out_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product));

    e_square_sched #(.WORDS(W), .LOG2_N(2), .TIMEOUT(TO)) u_two (
        .clk(clk), .rst_n(rst_n), .start(t_start), .in_data(t_in),
        .busy(t_busy), .done(t_done), .err(t_err), .iter(t_iter), .out_data(t_out),
        .mul_start(t_ms), .mul_a(t_a), .mul_b(t_b),
        .mul_done(t_md), .mul_product(t_prod));

    e_square_sched #(.WORDS(W), .LOG2_N(0), .TIMEOUT(TO)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(z_start), .in_data(z_in),
        .busy(z_busy), .done(z_done), .err(z_err), .iter(z_iter), .out_data(z_out),
        .mul_start(z_ms), .mul_a(z_a), .mul_b(z_b),
        .mul_done(z_md), .mul_product(z_prod));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pw(input logic [63:0] x, input int k);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = r * r;
        return r;
    endfunction

    // Stimulus knobs
    int lat = 5;
    int hold_pass = -1;
    int pidx = -1;
    bit spur = 1'b0;

    // Main multiplier model: product = A*A mod 2^64, lat cycles after mul_start
    bit          pend = 1'b0, hold_cur = 1'b0, mdone_r = 1'b0;
    int          mcnt = 0;
    logic [63:0] ma = '0, prod_r = '0;
    assign mul_done    = mdone_r | spur;
    assign mul_product = prod_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0; mdone_r = 1'b0; prod_r = '0;
        end else begin
            mdone_r = 1'b0;
            prod_r  = {$urandom, $urandom};
            if (pend) begin
                mcnt--;
                if (mcnt == 0) begin
                    pend = 1'b0;
                    if (!hold_cur) begin
                        mdone_r = 1'b1;
                        prod_r  = ma * ma;
                    end
                end
            end
            if (mul_start) begin
                pend = 1'b1; mcnt = lat; ma = mul_a; pidx++;
                hold_cur = (pidx == hold_pass);
            end
        end
    end

    // Second-instance multiplier, latency 3
    bit          t_pend = 1'b0;
    int          t_cnt = 0;
    logic [63:0] t_ma = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            t_pend = 1'b0; t_md = 1'b0; t_prod = '0;
        end else begin
            t_md = 1'b0; t_prod = {$urandom, $urandom};
            if (t_pend) begin
                t_cnt--;
                if (t_cnt == 0) begin t_pend = 1'b0; t_md = 1'b1; t_prod = t_ma * t_ma; end
            end
            if (t_ms) begin t_pend = 1'b1; t_cnt = 3; t_ma = t_a; end
        end
    end

    // Reference model for the main instance, advanced on each rising edge
    int          cyc = 0;
    bit          active = 1'b0, abort_run = 1'b0;
    int          acc = 0, end_d = 0, cap = 0, ms_cnt = 0, lat_run = 1;
    logic [63:0] x_run = '0, last_bank = '0;
    int          last_iter = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            active = 1'b0; last_bank = '0; last_iter = 0;
        end else if (active) begin
            if (cyc - acc == end_d) begin
                active = 1'b0; last_iter = cap; last_bank = pw(x_run, cap);
            end
        end else if (start) begin
            active    = 1'b1;
            acc       = cyc + 1;
            x_run     = in_data;
            lat_run   = lat;
            abort_run = (hold_pass >= 0) && (hold_pass < N);
            cap       = abort_run ? hold_pass : N;
            ms_cnt    = abort_run ? hold_pass + 1 : N;
            end_d     = abort_run ? hold_pass * (lat + 1) + TO + 1 : N * (lat + 1);
        end
        cyc++;
    end

    // Per-cycle compare
    int ms_count = 0, z_ms_count = 0;
    always @(negedge clk) begin
        int d, it;
        logic [63:0] eb;
        logic e_busy, e_done, e_err, e_ms;
        #1;
        if (mul_start) ms_count++;
        if (z_ms) z_ms_count++;
        if (!rst_n) begin
            eb = '0; it = 0; e_busy = 0; e_done = 0; e_err = 0; e_ms = 0;
        end else if (active) begin
            d  = cyc - acc;
            it = d / (lat_run + 1);
            if (it > cap) it = cap;
            eb     = pw(x_run, it);
            e_busy = d < end_d;
            e_done = !abort_run && (d == end_d);
            e_err  = abort_run && (d == end_d);
            e_ms   = (d % (lat_run + 1) == 0) && (d / (lat_run + 1) < ms_cnt);
        end else begin
            eb = last_bank; it = last_iter; e_busy = 0; e_done = 0; e_err = 0; e_ms = 0;
        end
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("err", 64'(err), 64'(e_err));
        check("mul_start", 64'(mul_start), 64'(e_ms));
        check("iter", 64'(iter), 64'(it));
        check("out_data", out_data, eb);
        check("mul_a", mul_a, eb);
        check("mul_b", mul_b, eb);
    end

    task automatic run_main(input logic [63:0] x, input int l, input int hp,
                            output int dt, output bit saw_err);
        int t0;
        bit seen;
        @(negedge clk);
        lat = l; hold_pass = hp; pidx = -1; ms_count = 0;
        in_data = x; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0; in_data = {$urandom, $urandom};
        seen = 1'b0; saw_err = 1'b0; dt = 0;
        for (int i = 0; i < 400; i++) begin
            #2;
            if (done || err) begin seen = 1'b1; saw_err = err; dt = cyc - t0; break; end
            @(negedge clk);
        end
        if (!seen) check("run_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int dt, t0;
        bit se, seen;
        logic [63:0] b;

        #2;
        check("rst_z_out", z_out, 64'h0);
        check("rst_t_iter", 64'(t_iter), 64'h0);
        check("rst_t_ms", 64'(t_ms), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // LOG2_N=0: result is the input, one cycle later, no multiplier use
        @(negedge clk);
        z_in = 64'h1234; z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0; z_in = '0;
        #2;
        check("zero_done", 64'(z_done), 64'h1);
        check("zero_out", z_out, 64'h1234);
        check("zero_busy", 64'(z_busy), 64'h0);
        @(negedge clk); #2;
        check("zero_done_pulse", 64'(z_done), 64'h0);
        check("zero_out_held", z_out, 64'h1234);

        // LOG2_N=2, L=3: (2^16+1)^4 mod 2^64, done at T+1+2*4
        @(negedge clk);
        t_in = 64'h0000_0000_0001_0001; t_start = 1'b1; t0 = cyc;
        @(negedge clk);
        t_start = 1'b0; t_in = '0;
        seen = 1'b0; dt = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (t_done) begin seen = 1'b1; dt = cyc - t0; break; end
            @(negedge clk);
        end
        check("two_seen", 64'(seen), 64'h1);
        check("two_latency", 64'(dt), 64'd9);
        check("two_out", t_out, 64'h0004_0006_0004_0001);

        // Main: X=2, L=5 -> 0x100 at T+19 with three passes
        run_main(64'h2, 5, -1, dt, se);
        check("a_latency", 64'(dt), 64'd19);
        check("a_out", out_data, 64'h100);
        check("a_passes", 64'(ms_count), 64'd3);
        check("a_iter", 64'(iter), 64'd3);
        check("a_err", 64'(se), 64'h0);

        // Watchdog: pass 1 never completes; bank keeps 3^2 and iter shows 1
        run_main(64'h3, 3, 1, dt, se);
        check("wd_err", 64'(se), 64'h1);
        check("wd_latency", 64'(dt), 64'd22);
        check("wd_out", out_data, 64'h9);
        check("wd_iter", 64'(iter), 64'd1);
        check("wd_busy", 64'(busy), 64'h0);

        for (int r = 0; r < 12; r++) begin
            int hp;
            hp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_main({$urandom, $urandom}, int'($urandom_range(1, 6)), hp, dt, se);
        end

        // start held through the run, then spurious mul_done while idle
        @(negedge clk);
        lat = 2; hold_pass = -1; pidx = -1; ms_count = 0;
        in_data = 64'h5; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        check("held_seen", 64'(seen), 64'h1);
        check("held_passes", 64'(ms_count), 64'd3);
        check("held_out", out_data, 64'h5F5E1);
        b = out_data;
        repeat (3) begin
            @(negedge clk); spur = 1'b1;
            @(negedge clk); spur = 1'b0;
        end
        @(negedge clk); #2;
        check("spur_out", out_data, b);
        check("spur_iter", 64'(iter), 64'd3);
        check("spur_busy", 64'(busy), 64'h0);

        // Reset during the third pass, then a clean run
        @(negedge clk);
        lat = 4; hold_pass = -1; pidx = -1;
        in_data = 64'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ms", 64'(mul_start), 64'h0);
        check("rst_iter", 64'(iter), 64'h0);
        check("rst_out", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ms_count = 0;
        repeat (10) @(negedge clk);
        #2;
        check("rst_no_ms", 64'(ms_count), 64'h0);
        run_main(64'h7, 4, -1, dt, se);
        check("post_rst_latency", 64'(dt), 64'd16);
        check("post_rst_out", out_data, 64'h57F6C1);
        check("zero_no_ms", 64'(z_ms_count), 64'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "bench timeout");
    end

endmodule
